// File: rtl/ex_mem_pipe_reg.sv
// rtl/ex_mem_pipe_reg.sv - EX/MEM pipeline register with a two-entry skid buffer
//
// Purpose: holds one EX->MEM transfer in a main entry that drives the outputs,
// with a skid entry that absorbs one extra transfer while MEM stalls. This
// keeps in_ready a function of registered state only, with no path from
// out_ready.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   flush                  synchronous kill, empties the stage
//   in_valid / in_ready    upstream handshake
//   in_ctrl, in_alu_result, in_val_rm, in_dest    payload from EX
//   out_valid / out_ready  downstream handshake
//   out_ctrl, out_alu_result, out_val_rm, out_dest    payload to MEM
//   occupancy              number of held entries (0..2)
module ex_mem_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 4,
    parameter int CTRL_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_val_rm,
    input  logic [DEST_W-1:0] in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [DATA_W-1:0] out_val_rm,
    output logic [DEST_W-1:0] out_dest,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;

    // Entry valid bits are implied by the state: main is valid in ONE/FULL,
    // skid only in FULL.
    logic              main_valid;
    logic              skid_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_alu_result;
    logic [DATA_W-1:0] main_val_rm;
    logic [DEST_W-1:0] main_dest;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_alu_result;
    logic [DATA_W-1:0] skid_val_rm;
    logic [DEST_W-1:0] skid_dest;

    logic in_fire;
    logic out_fire;

    assign main_valid = (state == ONE) || (state == FULL);
    assign skid_valid = (state == FULL);

    assign in_ready  = !skid_valid && !reset;
    assign out_valid = main_valid;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = main_valid && out_ready;

    // Control is gated on a bubble so no write/read enable can leak into MEM;
    // the data payload simply holds its last value.
    assign out_ctrl       = main_valid ? main_ctrl : '0;
    assign out_alu_result = main_alu_result;
    assign out_val_rm     = main_val_rm;
    assign out_dest       = main_dest;

    always_comb begin
        occupancy = 2'd0;
        case (state)
            EMPTY:   occupancy = 2'd0;
            ONE:     occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= EMPTY;
            main_ctrl       <= '0;
            main_alu_result <= '0;
            main_val_rm     <= '0;
            main_dest       <= '0;
            skid_ctrl       <= '0;
            skid_alu_result <= '0;
            skid_val_rm     <= '0;
            skid_dest       <= '0;
        end else if (flush) begin
            // Payload registers keep their contents; only occupancy is dropped.
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_ctrl       <= in_ctrl;
                        main_alu_result <= in_alu_result;
                        main_val_rm     <= in_val_rm;
                        main_dest       <= in_dest;
                        state           <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_ctrl       <= in_ctrl;
                        main_alu_result <= in_alu_result;
                        main_val_rm     <= in_val_rm;
                        main_dest       <= in_dest;
                    end else if (in_fire) begin
                        skid_ctrl       <= in_ctrl;
                        skid_alu_result <= in_alu_result;
                        skid_val_rm     <= in_val_rm;
                        skid_dest       <= in_dest;
                        state           <= FULL;
                    end else if (out_fire) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_ctrl       <= skid_ctrl;
                        main_alu_result <= skid_alu_result;
                        main_val_rm     <= skid_val_rm;
                        main_dest       <= skid_dest;
                        state           <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// tb/tb_ex_mem_pipe_reg.sv - self-checking bench for ex_mem_pipe_reg
module tb_ex_mem_pipe_reg;

    typedef struct packed {
        logic [2:0]  ctrl;
        logic [31:0] alu;
        logic [31:0] rm;
        logic [3:0]  dest;
    } entry_t;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_ctrl;
    logic [31:0] in_alu_result;
    logic [31:0] in_val_rm;
    logic [3:0]  in_dest;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_ctrl;
    logic [31:0] out_alu_result;
    logic [31:0] out_val_rm;
    logic [3:0]  out_dest;
    logic [1:0]  occupancy;

    int checks = 0;
    int errors = 0;

    entry_t q[$];
    entry_t last_front;

    ex_mem_pipe_reg #(.DATA_W(32), .DEST_W(4), .CTRL_W(3)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_ctrl        (in_ctrl),
        .in_alu_result  (in_alu_result),
        .in_val_rm      (in_val_rm),
        .in_dest        (in_dest),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_ctrl       (out_ctrl),
        .out_alu_result (out_alu_result),
        .out_val_rm     (out_val_rm),
        .out_dest       (out_dest),
        .occupancy      (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output against the queue model.
    task automatic check_all(input string tag);
        entry_t e;
        int     n;
        n = q.size();
        e = (n > 0) ? q[0] : last_front;
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(n > 0));
        chk({tag, ".occupancy"}, 32'(occupancy), 32'(n));
        chk({tag, ".in_ready"},  32'(in_ready),  32'((n < 2) && !reset));
        chk({tag, ".out_ctrl"},  32'(out_ctrl),  (n > 0) ? 32'(e.ctrl) : 32'd0);
        chk({tag, ".out_alu"},   out_alu_result, e.alu);
        chk({tag, ".out_rm"},    out_val_rm,     e.rm);
        chk({tag, ".out_dest"},  32'(out_dest),  32'(e.dest));
    endtask

    // One cycle: drive inputs, update the FIFO model at the edge, check at negedge.
    task automatic step(input string tag, input logic r, input logic f, input logic iv,
                        input logic [2:0] c, input logic [31:0] a, input logic [3:0] d,
                        input logic ordy);
        entry_t e;
        bit     in_f;
        bit     out_f;
        reset         = r;
        flush         = f;
        in_valid      = iv;
        in_ctrl       = c;
        in_alu_result = a;
        in_val_rm     = ~a;
        in_dest       = d;
        out_ready     = ordy;
        e    = '{ctrl: c, alu: a, rm: ~a, dest: d};
        in_f = iv && !r && (q.size() < 2);
        out_f = (q.size() > 0) && ordy;
        @(posedge clk);
        if (r) begin
            q.delete();
            last_front = '0;
        end else if (f) begin
            q.delete();
        end else begin
            if (out_f) void'(q.pop_front());
            if (in_f) q.push_back(e);
        end
        if (q.size() > 0) last_front = q[0];
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        q.delete();
        last_front = '0;

        // Reset state (in_ready must be 0 while reset is held)
        step("rst0", 1, 0, 0, 3'b000, 32'h0, 4'h0, 0);
        step("rst1", 1, 0, 1, 3'b111, 32'hDEAD, 4'hF, 1);

        // Bubble gating in EMPTY
        step("bubble0", 0, 0, 0, 3'b111, 32'h99, 4'h3, 0);
        step("bubble1", 0, 0, 0, 3'b111, 32'h98, 4'h3, 1);

        // Pass-through at full throughput
        step("pass0", 0, 0, 1, 3'b001, 32'h11, 4'hA, 1);
        step("pass1", 0, 0, 1, 3'b001, 32'h22, 4'hA, 1);
        step("pass2", 0, 0, 1, 3'b001, 32'h33, 4'hA, 1);
        step("pass3", 0, 0, 0, 3'b000, 32'h0, 4'h0, 1);
        step("pass4", 0, 0, 0, 3'b000, 32'h0, 4'h0, 1);

        // Backpressure into the skid entry, then drain in order
        step("bp0", 0, 0, 1, 3'b010, 32'hA1, 4'h1, 0);
        step("bp1", 0, 0, 1, 3'b010, 32'hB2, 4'h2, 0);
        step("bp2", 0, 0, 1, 3'b010, 32'hC3, 4'h3, 0);
        step("bp3", 0, 0, 0, 3'b000, 32'h0, 4'h0, 1);
        step("bp4", 0, 0, 0, 3'b000, 32'h0, 4'h0, 1);
        step("bp5", 0, 0, 0, 3'b000, 32'h0, 4'h0, 1);

        // Simultaneous in/out while ONE
        step("sim0", 0, 0, 1, 3'b001, 32'h5, 4'h5, 0);
        step("sim1", 0, 0, 1, 3'b001, 32'h6, 4'h6, 1);
        step("sim2", 0, 0, 0, 3'b000, 32'h0, 4'h0, 1);

        // Flush from FULL together with an offered transfer
        step("fl0", 0, 0, 1, 3'b011, 32'h55, 4'h7, 0);
        step("fl1", 0, 0, 1, 3'b011, 32'h66, 4'h7, 0);
        step("fl2", 0, 1, 1, 3'b011, 32'h77, 4'h7, 1);
        step("fl3", 0, 0, 0, 3'b000, 32'h0, 4'h0, 1);

        // Reset in FULL with a store control vector
        step("rm0", 0, 0, 1, 3'b100, 32'h81, 4'h8, 0);
        step("rm1", 0, 0, 1, 3'b100, 32'h82, 4'h8, 0);
        step("rm2", 1, 0, 0, 3'b100, 32'h0, 4'h0, 1);
        step("rm3", 0, 0, 0, 3'b100, 32'h0, 4'h0, 1);
        step("rm4", 0, 0, 0, 3'b100, 32'h0, 4'h0, 1);

        // Randomized traffic against the FIFO model
        for (int i = 0; i < 400; i++) begin
            step("rnd",
                 ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 9) < 7),
                 3'($urandom),
                 $urandom,
                 4'($urandom),
                 ($urandom_range(0, 9) < 6));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
